// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_mem
// Purpose  : APB completer backed by a word-addressed memory, with a fixed
//            number of wait states per transfer. Macro APB_SLV_PSLVERR_EN
//            turns out-of-range accesses into error responses; without it,
//            addresses wrap modulo MEM_DEPTH.
// Revision : 1.0  initial release
// ============================================================================

module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr
);

  localparam int         c_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_cnt;
  logic                  r_pready;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_setup;
  logic                  w_active;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  w_sel_write;
  logic [c_IDX_W-1:0]    w_sel_idx;
  logic                  w_sel_oob;
  logic [DATA_WIDTH-1:0] w_sel_rdata;

  assign w_setup  = pselx & ~penable;
  assign w_active = pselx & penable;

  // Outside ACCESS the response is built from the live setup-phase bus so a
  // zero-wait transfer can present pready/prdata in its first access cycle.
  assign w_sel_addr  = (r_state == ST_ACCESS) ? r_addr  : paddr;
  assign w_sel_write = (r_state == ST_ACCESS) ? r_write : pwrite;
  assign w_sel_idx   = (MEM_DEPTH > 1) ? c_IDX_W'(w_sel_addr) : '0;

`ifdef APB_SLV_PSLVERR_EN
  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  assign w_sel_oob = ({1'b0, w_sel_addr} >= c_DEPTH);
`else
  assign w_sel_oob = 1'b0;
`endif

  assign w_sel_rdata = w_sel_oob ? '0 : r_mem[w_sel_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          if (w_setup) begin
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_cnt   <= c_WAIT;
            r_state <= ST_ACCESS;
            if (WAIT_STATES == 0) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_sel_oob;
              if (!w_sel_write) begin
                r_prdata <= w_sel_rdata;
              end
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_ACCESS: begin
          if (!w_active) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (r_pready) begin
            if (r_write && !w_sel_oob) begin
              r_mem[w_sel_idx] <= r_wdata;
            end
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            // Last wait cycle: the response registers load for the next cycle.
            if (r_cnt == 4'd1) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_sel_oob;
              if (!w_sel_write) begin
                r_prdata <= w_sel_rdata;
              end
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pready  = r_pready;
  assign prdata  = r_prdata;
  assign pslverr = r_pslverr;

endmodule

`default_nettype wire
